// File: rtl/ps2_tty_pkg.sv
// Shared scancode/ASCII constants, decoder types and the set-2 to ASCII map.
package ps2_tty_pkg;

    // Set-2 scancodes with special meaning to the decoder
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    // ASCII codes for the non-printing keys
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_CASE  = 7'h20;  // lower minus upper case

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    typedef struct packed {
        logic       hit;
        logic [6:0] ch;
    } ascii_map_t;

    typedef enum logic {
        DEC_NORMAL,
        DEC_BREAK
    } dec_state_e;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

    // Frame is bit 0 = start ... bit 10 = stop; parity is odd over data+parity
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] frame);
        return !frame[0] && frame[FRAME_BITS-1] && (^frame[9:1]);
    endfunction

    function automatic ascii_map_t scancode_to_ascii(input logic [7:0] code,
                                                     input logic       shift);
        ascii_map_t m;
        logic [6:0] lower;
        m.hit = 1'b1;
        m.ch  = 7'h00;
        lower = 7'h00;
        case (code)
            8'h1C: lower = 7'h61;  // a
            8'h32: lower = 7'h62;  // b
            8'h21: lower = 7'h63;  // c
            8'h23: lower = 7'h64;  // d
            8'h24: lower = 7'h65;  // e
            8'h2B: lower = 7'h66;  // f
            8'h34: lower = 7'h67;  // g
            8'h33: lower = 7'h68;  // h
            8'h43: lower = 7'h69;  // i
            8'h3B: lower = 7'h6A;  // j
            8'h42: lower = 7'h6B;  // k
            8'h4B: lower = 7'h6C;  // l
            8'h3A: lower = 7'h6D;  // m
            8'h31: lower = 7'h6E;  // n
            8'h44: lower = 7'h6F;  // o
            8'h4D: lower = 7'h70;  // p
            8'h15: lower = 7'h71;  // q
            8'h2D: lower = 7'h72;  // r
            8'h1B: lower = 7'h73;  // s
            8'h2C: lower = 7'h74;  // t
            8'h3C: lower = 7'h75;  // u
            8'h2A: lower = 7'h76;  // v
            8'h1D: lower = 7'h77;  // w
            8'h22: lower = 7'h78;  // x
            8'h35: lower = 7'h79;  // y
            8'h1A: lower = 7'h7A;  // z
            default: lower = 7'h00;
        endcase

        if (lower != 7'h00) begin
            m.ch = shift ? (lower - ASCII_CASE) : lower;
        end else begin
            case (code)
                8'h16:    m.ch = shift ? 7'h21 : 7'h31;  // ! 1
                8'h1E:    m.ch = shift ? 7'h40 : 7'h32;  // @ 2
                8'h26:    m.ch = shift ? 7'h23 : 7'h33;  // # 3
                8'h25:    m.ch = shift ? 7'h24 : 7'h34;  // $ 4
                8'h2E:    m.ch = shift ? 7'h25 : 7'h35;  // % 5
                8'h36:    m.ch = shift ? 7'h5E : 7'h36;  // ^ 6
                8'h3D:    m.ch = shift ? 7'h26 : 7'h37;  // & 7
                8'h3E:    m.ch = shift ? 7'h2A : 7'h38;  // * 8
                8'h46:    m.ch = shift ? 7'h28 : 7'h39;  // ( 9
                8'h45:    m.ch = shift ? 7'h29 : 7'h30;  // ) 0
                SC_SPACE: m.ch = ASCII_SPACE;
                SC_ENTER: m.ch = ASCII_CR;
                SC_BKSP:  m.ch = ASCII_BS;
                default:  m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises the lines, samples 11-bit frames
// on falling clock edges, and flags each well-formed byte for one cycle.
module ps2_rx
    import ps2_tty_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_in,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 1);

    logic                  clk_meta_q, clk_meta_d;
    logic                  clk_sync_q, clk_sync_d;
    logic                  clk_prev_q, clk_prev_d;
    logic                  dat_meta_q, dat_meta_d;
    logic                  dat_sync_q, dat_sync_d;
    logic [3:0]            bit_cnt_q,  bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q,    shift_d;
    logic [TO_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [7:0]            byte_q,     byte_d;
    logic                  valid_q,    valid_d;
    logic                  fall;
    logic [FRAME_BITS-1:0] frame;

    assign fall     = clk_prev_q && !clk_sync_q;
    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;

    // Next-state: synchroniser pipeline, bit shifting, frame check and timeout
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        clk_prev_d = clk_sync_q;
        dat_meta_d = ps2_in;
        dat_sync_d = dat_meta_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        idle_cnt_d = '0;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        // New bit enters at the top; after 11 edges the start bit sits at bit 0
        frame      = {dat_sync_q, shift_q[FRAME_BITS-1:1]};

        if (fall) begin
            shift_d = frame;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                if (frame_ok(frame)) begin
                    valid_d = 1'b1;
                    byte_d  = frame[8:1];
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != '0) begin
            // Mid-frame with no edge: abandon the frame once the line goes quiet
            if (idle_cnt_q == TO_LAST) begin
                bit_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end
    end

    // State registers; lines reset to their idle-high level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            idle_cnt_q <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the values
            // from before this edge, so the synchroniser stages really pipeline.
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            idle_cnt_q <= idle_cnt_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/ps2_tty_shell.sv
// Keyboard echo shell: PS/2 receiver, scancode decoder with shift/break
// tracking, character FIFO and the TTY write handshake.
module ps2_tty_shell
    import ps2_tty_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       SYS_CLK,
    input  logic       reset,
    input  logic       ps2_in,
    input  logic       ps2_clk,
    input  logic       TTY_ready,
    output logic [6:0] TTY_data,
    output logic       TTY_en,
    output logic       TTY_clear
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [7:0]       rx_byte;
    logic             rx_valid;

    dec_state_e       state_q, state_d;
    logic             shift_q, shift_d;
    logic             enq_valid_q, enq_valid_d;
    logic [6:0]       enq_char_q, enq_char_d;
    logic             clear_q, clear_d;
    logic             por_done_q, por_done_d;
    logic             esc_hit;
    ascii_map_t       map;

    logic [6:0]       mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty, push, pop;
    logic             tty_en_q, tty_en_d;
    logic [6:0]       tty_data_q, tty_data_d;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (SYS_CLK),
        .rst     (reset),
        .ps2_clk (ps2_clk),
        .ps2_in  (ps2_in),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid)
    );

    assign TTY_data  = tty_data_q;
    assign TTY_en    = tty_en_q;
    assign TTY_clear = clear_q;

    // Decoder: break/shift tracking, Esc clear and character lookup
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        enq_valid_d = 1'b0;
        enq_char_d  = enq_char_q;
        esc_hit     = 1'b0;
        por_done_d  = 1'b1;
        map         = scancode_to_ascii(rx_byte, shift_q);

        if (rx_valid) begin
            case (state_q)
                DEC_BREAK: begin
                    // Byte after F0 is a key release: never a character
                    state_d = DEC_NORMAL;
                    if (is_shift_code(rx_byte)) begin
                        shift_d = 1'b0;
                    end
                end
                default: begin
                    if (rx_byte == SC_BREAK) begin
                        state_d = DEC_BREAK;
                    end else if (rx_byte == SC_EXT) begin
                        state_d = DEC_NORMAL;  // prefix dropped
                    end else if (is_shift_code(rx_byte)) begin
                        shift_d = 1'b1;
                    end else if (rx_byte == SC_ESC) begin
                        esc_hit = 1'b1;
                    end else if (map.hit) begin
                        enq_valid_d = 1'b1;
                        enq_char_d  = map.ch;
                    end
                end
            endcase
        end

        // Clear once on the first edge out of reset, then on every Esc
        clear_d = !por_done_q || esc_hit;
    end

    // FIFO bookkeeping and TTY strobe; a strobe cycle never pops again
    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        fifo_full  = (count == DEPTH_C);
        fifo_empty = (count == '0);
        push       = enq_valid_q && !fifo_full;
        pop        = !tty_en_q && !fifo_empty && TTY_ready;
        wr_ptr_d   = push ? (wr_ptr_q + CNT_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + CNT_W'(1)) : rd_ptr_q;
        tty_en_d   = pop;
        tty_data_d = pop ? mem_q[rd_ptr_q[PTR_W-1:0]] : tty_data_q;
    end

    // Control and output registers
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            state_q     <= DEC_NORMAL;
            shift_q     <= 1'b0;
            enq_valid_q <= 1'b0;
            enq_char_q  <= '0;
            clear_q     <= 1'b0;
            por_done_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tty_en_q    <= 1'b0;
            tty_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            enq_valid_q <= enq_valid_d;
            enq_char_q  <= enq_char_d;
            clear_q     <= clear_d;
            por_done_q  <= por_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tty_en_q    <= tty_en_d;
            tty_data_q  <= tty_data_d;
        end
    end

    // Character storage
    always_ff @(posedge SYS_CLK) begin
        // NOTE: the array has no reset; the pointers define which entries are
        // meaningful, and a reset-free array can map onto plain RAM.
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= enq_char_q;
        end
    end

endmodule

// File: tb/tb_ps2_tty_shell.sv
// Scoreboard bench: stimulus pushes expected characters, a monitor pops and
// compares on every TTY strobe; random phase uses a table-driven key model.
module tb_ps2_tty_shell;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 8;
    localparam int GAP     = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_in  = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       TTY_ready = 1'b1;
    logic [6:0] TTY_data;
    logic       TTY_en;
    logic       TTY_clear;

    always #5 clk = ~clk;

    ps2_tty_shell #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .FIFO_DEPTH    (4)
    ) dut (
        .SYS_CLK  (clk),
        .reset    (reset),
        .ps2_in   (ps2_in),
        .ps2_clk  (ps2_clk),
        .TTY_ready(TTY_ready),
        .TTY_data (TTY_data),
        .TTY_en   (TTY_en),
        .TTY_clear(TTY_clear)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   n_en = 0;
    int   clear_cnt = 0;
    int   exp_clear = 0;
    bit   rand_ready = 1'b0;
    logic [6:0] last_data = '0;
    logic prev_en = 1'b0;
    logic prev_clear = 1'b0;

    // Reference key tables
    int    lo_map[int];
    int    hi_map[int];
    bit    m_shift = 1'b0;
    bit    m_brk = 1'b0;
    int    letter_codes[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43,
                                'h3B, 'h42, 'h4B, 'h3A, 'h31, 'h44, 'h4D, 'h15, 'h2D,
                                'h1B, 'h2C, 'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
    int    digit_codes[10] = '{'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46, 'h45};
    string letters = "abcdefghijklmnopqrstuvwxyz";
    string digits  = "1234567890";
    string symbols = "!@#$%^&*()";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void init_tables();
        for (int i = 0; i < 26; i++) begin
            lo_map[letter_codes[i]] = int'(letters[i]);
            hi_map[letter_codes[i]] = int'(letters[i]) - 32;
        end
        for (int i = 0; i < 10; i++) begin
            lo_map[digit_codes[i]] = int'(digits[i]);
            hi_map[digit_codes[i]] = int'(symbols[i]);
        end
        lo_map['h29] = 'h20; hi_map['h29] = 'h20;
        lo_map['h5A] = 'h0D; hi_map['h5A] = 'h0D;
        lo_map['h66] = 'h08; hi_map['h66] = 'h08;
    endfunction

    // Key-level behaviour: returns the character a byte produces, or -1
    function automatic int model_byte(input int b);
        if (m_brk) begin
            m_brk = 1'b0;
            if (b == 'h12 || b == 'h59) m_shift = 1'b0;
            return -1;
        end
        if (b == 'hF0) begin m_brk = 1'b1; return -1; end
        if (b == 'hE0) return -1;
        if (b == 'h12 || b == 'h59) begin m_shift = 1'b1; return -1; end
        if (b == 'h76) begin exp_clear++; return -1; end
        if (lo_map.exists(b)) return m_shift ? hi_map[b] : lo_map[b];
        return -1;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                               input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (rand_ready) TTY_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_in = frame[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_in = 1'b1;
        wait_cycles(GAP);
    endtask

    task automatic send_raw(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0, 1'b0), 11);
    endtask

    task automatic send_model(input logic [7:0] b);
        int ch;
        ch = model_byte(int'(b));
        if (ch >= 0) exp_q.push_back(ch);
        send_raw(b);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            tick();
            k++;
        end
        check("drain_done", exp_q.size(), 0);
        if (exp_q.size() != 0) exp_q.delete();
        wait_cycles(40);
    endtask

    // Monitor: scoreboard pop on every strobe, hold and spacing checks
    always @(negedge clk) begin
        if (reset) begin
            last_data  = '0;
            prev_en    = 1'b0;
            prev_clear = 1'b0;
        end else begin
            if (TTY_en) begin
                n_en++;
                check("no_back_to_back_en", prev_en, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_char: got %0h expected none", TTY_data);
                end else begin
                    check("tty_data", TTY_data, exp_q.pop_front());
                end
                last_data = TTY_data;
            end else begin
                check("data_hold", TTY_data, last_data);
            end
            if (TTY_clear) begin
                clear_cnt++;
                check("no_back_to_back_clear", prev_clear, 0);
            end
            prev_en    = TTY_en;
            prev_clear = TTY_clear;
        end
    end

    // Stimulus
    initial begin
        logic [10:0] f;
        int          snap;
        int          r;
        logic [7:0]  b;

        init_tables();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tty_en", TTY_en, 0);
        check("rst_tty_data", TTY_data, 0);
        check("rst_tty_clear", TTY_clear, 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("por_clear_high", TTY_clear, 1);
        @(posedge clk); #1;
        check("por_clear_low", TTY_clear, 0);
        exp_clear = 1;
        wait_cycles(5);
        check("por_clear_count", clear_cnt, exp_clear);

        // Plain letter, shifted letter, shift release
        exp_q.push_back('h61); send_raw('h1C); drain();
        exp_q.push_back('h48); send_raw('h12); send_raw('h33); drain();
        send_raw('hF0); send_raw('h12);
        exp_q.push_back('h68); send_raw('h33); drain();

        // Typematic repeat and a released letter
        exp_q.push_back('h61); exp_q.push_back('h61);
        send_raw('h1C); send_raw('h1C);
        send_raw('hF0); send_raw('h1C); drain();

        // Bad parity, bad stop, bad start are discarded
        send_bits(make_frame('h1C, 1'b1, 1'b0), 11);
        send_bits(make_frame('h1C, 1'b0, 1'b1), 11);
        f = make_frame('h1C, 1'b0, 1'b0);
        f[0] = 1'b1;
        send_bits(f, 11);
        exp_q.push_back('h61); send_raw('h1C); drain();

        // Partial frame abandoned by timeout
        send_bits(make_frame('h33, 1'b0, 1'b0), 4);
        wait_cycles(TIMEOUT + 50);
        exp_q.push_back('h61); send_raw('h1C); drain();

        // Right shift digits, E0 prefix, space, backspace, unmapped code
        send_raw('h59);
        exp_q.push_back('h21); send_raw('h16);
        exp_q.push_back('h40); send_raw('h1E);
        send_raw('hF0); send_raw('h59);
        exp_q.push_back('h32); send_raw('h1E);
        send_raw('hE0); exp_q.push_back('h0D); send_raw('h5A);
        exp_q.push_back('h20); send_raw('h29);
        exp_q.push_back('h08); send_raw('h66);
        send_raw('h05);
        drain();

        // Stall with five characters into a four-deep buffer
        TTY_ready = 1'b0;
        snap = n_en;
        send_raw('h1C); send_raw('h33); send_raw('h29); send_raw('h16); send_raw('h5A);
        wait_cycles(50);
        check("stall_no_output", n_en, snap);
        exp_q.push_back('h61); exp_q.push_back('h68);
        exp_q.push_back('h20); exp_q.push_back('h31);
        TTY_ready = 1'b1;
        drain();
        check("full_drop_count", n_en - snap, 4);

        // Esc while a character is pending
        TTY_ready = 1'b0;
        snap = n_en;
        exp_q.push_back('h61); send_raw('h1C);
        exp_clear++; send_raw('h76);
        wait_cycles(10);
        check("esc_clear_count", clear_cnt, exp_clear);
        check("esc_no_output", n_en, snap);
        TTY_ready = 1'b1;
        drain();

        // Reset in the middle of a frame
        send_bits(make_frame('h1C, 1'b0, 1'b0), 5);
        @(negedge clk); #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_tty_en", TTY_en, 0);
        check("midrst_tty_clear", TTY_clear, 0);
        #2 reset = 1'b0;
        m_shift = 1'b0;
        m_brk   = 1'b0;
        exp_clear++;
        send_model('h76);
        wait_cycles(20);
        check("midrst_clear_count", clear_cnt, exp_clear);
        drain();

        // Random keystrokes against the model, random display readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      b = 8'(letter_codes[$urandom_range(0, 25)]);
            else if (r < 60) b = 8'(digit_codes[$urandom_range(0, 9)]);
            else if (r < 70) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            else if (r < 80) b = 8'hF0;
            else if (r < 84) b = 8'hE0;
            else if (r < 88) b = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h66;
            else if (r < 90) b = 8'h76;
            else             b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) send_bits(make_frame(b, 1'b1, 1'b0), 11);
            else                           send_model(b);
        end
        rand_ready = 1'b0;
        TTY_ready  = 1'b1;
        drain();
        check("final_clear_count", clear_cnt, exp_clear);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d mismatched so far", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
